// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic unit and its writeback stage.
// A beat is packed as {op[1:0], v, z, c, f[W-1:0]}.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_PASS = 2'b10,
    OP_DEC  = 2'b11
  } op_e;

  // op (2) + v + z + c ride alongside the result
  localparam int FLAG_W = 5;

  function automatic int beat_width(input int w);
    return w + FLAG_W;
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic two-entry skid buffer: an output register plus one skid slot, so that
// in_ready depends only on local state and never on out_ready.
module alu_skid_buf #(
  parameter int BEAT_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data
);

  logic              skid_valid;
  logic [BEAT_W-1:0] skid_data;
  logic              accept;
  logic              load_out;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign load_out = ~out_valid | out_ready;

  // The skid slot always drains first, so FIFO order holds; while it is full
  // in_ready is low and no new beat can race it into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (load_out) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) begin
          out_data <= in_data;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered writeback stage after the 8-bit arithmetic unit: skid-buffered
// result/flags plus sticky carry/overflow, zero-flag consistency and a beat counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_f,
  input  logic             in_c,
  input  logic             in_z,
  input  logic             in_v,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_f,
  output logic             out_c,
  output logic             out_z,
  output logic             out_v,
  output logic [1:0]       out_op,
  input  logic             sticky_clr,
  output logic             sticky_c,
  output logic             sticky_v,
  output logic             z_err,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int BEAT_W = beat_width(W);

  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] out_beat;
  logic              accept;
  logic              z_bad;

  assign in_beat = {in_op, in_v, in_z, in_c, in_f};
  assign {out_op, out_v, out_z, out_c, out_f} = out_beat;

  alu_skid_buf #(.BEAT_W(BEAT_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_beat)
  );

  assign accept = in_valid & in_ready;
  assign z_bad  = in_z ^ (in_f == '0);

  // A set on the same cycle as a clear wins, so no accepted event is ever dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_c <= 1'b0;
      sticky_v <= 1'b0;
      z_err    <= 1'b0;
    end else begin
      sticky_c <= (sticky_c & ~sticky_clr) | (accept & in_c);
      sticky_v <= (sticky_v & ~sticky_clr) | (accept & in_v);
      z_err    <= (z_err & ~sticky_clr) | (accept & z_bad);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (accept && (beat_cnt != '1)) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: scoreboard on the output handshake,
// a reference model for sticky/counter state, table vectors and corner sequences.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int BW    = W + 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_f = '0;
  logic             in_c = 1'b0;
  logic             in_z = 1'b0;
  logic             in_v = 1'b0;
  logic [1:0]       in_op = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_f;
  logic             out_c;
  logic             out_z;
  logic             out_v;
  logic [1:0]       out_op;
  logic             sticky_clr = 1'b0;
  logic             sticky_c;
  logic             sticky_v;
  logic             z_err;
  logic [CNT_W-1:0] beat_cnt;

  alu_result_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_f       (in_f),
    .in_c       (in_c),
    .in_z       (in_z),
    .in_v       (in_v),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .out_c      (out_c),
    .out_z      (out_z),
    .out_v      (out_v),
    .out_op     (out_op),
    .sticky_clr (sticky_clr),
    .sticky_c   (sticky_c),
    .sticky_v   (sticky_v),
    .z_err      (z_err),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] f;
    logic         c;
    logic         z;
    logic         v;
    logic [1:0]   op;
  } vec_t;

  vec_t          vecs[8];
  logic [BW-1:0] sb_q[$];
  int            errors = 0;
  int            checks = 0;
  bit            rand_ready = 1'b0;

  logic             m_c = 1'b0;
  logic             m_v = 1'b0;
  logic             m_zerr = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             prev_held = 1'b0;
  logic [BW-1:0]    prev_beat = '0;
  logic [BW-1:0]    cur_beat;
  logic             mon_acc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Offer one beat and return #1 after the edge that accepted it; in_valid stays high.
  task automatic applyStimulus(input logic [W-1:0] f, input logic c, input logic z,
                               input logic v, input logic [1:0] op);
    bit ok;
    ok = 1'b0;
    in_f = f; in_c = c; in_z = z; in_v = v; in_op = op;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: beat 0x%0h never accepted, want accepted", f);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle when everything is stable.
  always @(negedge clk) begin
    cur_beat = {out_op, out_v, out_z, out_c, out_f};
    if (!rst_n) begin
      sb_q.delete();
      m_c = 1'b0; m_v = 1'b0; m_zerr = 1'b0; m_cnt = '0;
      prev_held = 1'b0;
    end else begin
      checkOutput("sticky_c", 32'(sticky_c), 32'(m_c));
      checkOutput("sticky_v", 32'(sticky_v), 32'(m_v));
      checkOutput("z_err", 32'(z_err), 32'(m_zerr));
      checkOutput("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
      if (prev_held) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_beat", 32'(cur_beat), 32'(prev_beat));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL out_beat: got 0x%0h, want no beat", cur_beat);
        end else begin
          checkOutput("out_beat", 32'(cur_beat), 32'(sb_q.pop_front()));
        end
      end
      mon_acc = in_valid && in_ready;
      m_c    = (m_c & ~sticky_clr) | (mon_acc & in_c);
      m_v    = (m_v & ~sticky_clr) | (mon_acc & in_v);
      m_zerr = (m_zerr & ~sticky_clr) | (mon_acc & (in_z ^ (in_f == 8'h00)));
      if (mon_acc) begin
        sb_q.push_back({in_op, in_v, in_z, in_c, in_f});
        if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
      prev_held = out_valid && !out_ready;
      prev_beat = cur_beat;
    end
  end

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(posedge clk);
    #1;
    checkOutput("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] seq[3];
    vecs[0] = '{f: 8'h01, c: 1'b0, z: 1'b0, v: 1'b0, op: OP_ADD};
    vecs[1] = '{f: 8'hFF, c: 1'b1, z: 1'b0, v: 1'b0, op: OP_SUB};
    vecs[2] = '{f: 8'h00, c: 1'b1, z: 1'b1, v: 1'b0, op: OP_ADD};
    vecs[3] = '{f: 8'h7F, c: 1'b0, z: 1'b0, v: 1'b1, op: OP_SUB};
    vecs[4] = '{f: 8'hA5, c: 1'b0, z: 1'b0, v: 1'b0, op: OP_PASS};
    vecs[5] = '{f: 8'h10, c: 1'b0, z: 1'b1, v: 1'b0, op: OP_DEC};
    vecs[6] = '{f: 8'h5A, c: 1'b1, z: 1'b0, v: 1'b1, op: OP_DEC};
    vecs[7] = '{f: 8'h00, c: 1'b0, z: 1'b0, v: 1'b0, op: OP_PASS};
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Reset while the output register and skid slot are both full
    out_ready = 1'b0;
    applyStimulus(8'hA1, 1'b1, 1'b1, 1'b1, OP_ADD);
    applyStimulus(8'hA2, 1'b1, 1'b0, 1'b1, OP_SUB);
    in_valid = 1'b0;
    checkOutput("pre_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_in_ready", 32'(in_ready), 32'd1);
    checkOutput("async_beat_cnt", 32'(beat_cnt), 32'd0);
    checkOutput("async_sticky", 32'({sticky_c, sticky_v, z_err}), 32'd0);
    checkOutput("async_out_f", 32'(out_f), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single beat, one-cycle latency
    out_ready = 1'b1;
    applyStimulus(8'h80, 1'b0, 1'b0, 1'b1, OP_ADD);
    in_valid = 1'b0;
    checkOutput("single_out_valid", 32'(out_valid), 32'd1);
    checkOutput("single_out_f", 32'(out_f), 32'h80);
    checkOutput("single_out_v", 32'(out_v), 32'd1);
    checkOutput("single_sticky_v", 32'(sticky_v), 32'd1);
    checkOutput("single_beat_cnt", 32'(beat_cnt), 32'd1);

    // Backpressure fills the skid, then drains in order without gaps
    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, OP_PASS);
    applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, OP_PASS);
    in_f = 8'h33;
    repeat (2) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_f", 32'(out_f), 32'h11);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_seq_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_seq_f", 32'(out_f), 32'(seq[k]));
      if (in_valid && in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    end

    // Clear and set of sticky_v in the same cycle
    @(posedge clk);
    #1 sticky_clr = 1'b1;
    applyStimulus(8'h44, 1'b0, 1'b0, 1'b1, OP_SUB);
    in_valid = 1'b0;
    checkOutput("race_sticky_v", 32'(sticky_v), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("clr_sticky_v", 32'(sticky_v), 32'd0);
    sticky_clr = 1'b0;

    // Zero-flag inconsistency is sticky until cleared
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, OP_PASS);
    in_valid = 1'b0;
    checkOutput("zchk_set", 32'(z_err), 32'd1);
    applyStimulus(8'h05, 1'b0, 1'b0, 1'b0, OP_DEC);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("zchk_hold", 32'(z_err), 32'd1);
    sticky_clr = 1'b1;
    @(posedge clk);
    #1 sticky_clr = 1'b0;
    checkOutput("zchk_clr", 32'(z_err), 32'd0);

    // Table vectors streamed back-to-back with random backpressure
    rand_ready = 1'b1;
    foreach (vecs[i]) applyStimulus(vecs[i].f, vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].op);
    in_valid = 1'b0;
    rand_ready = 1'b0;
    drain();

    // Counter saturation from a fresh reset
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(8'(i + 1), 1'b0, 1'b0, 1'b0, OP_ADD);
    in_valid = 1'b0;
    rand_ready = 1'b0;
    checkOutput("sat_cnt", 32'(beat_cnt), 32'hF);
    drain();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sat_hold", 32'(beat_cnt), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
